accuracy_monitor: RTL and testbench

- Sits directly downstream of the DNN top level. Consumes the one-hot prediction `actL_alln` and the serialized ideal output `ansL`.
- Rebuilds the full ideal-output vector over each block cycle and compares it with the prediction at the block boundary.
- Accumulates per-window correct/total counts and hands each window's result out through a valid/ready handshake. Used for on-chip training-accuracy tracking.

---
 rtl/accuracy_monitor.sv | 174 +++++++++++++++++
 tb/tb_accuracy_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accuracy_monitor.sv
// accuracy_monitor
//   Tracks training accuracy downstream of the DNN top level. The serialized
//   ideal output (ansL, zo bits per clock) is reassembled into an n_out-bit
//   vector over each block cycle. At the block boundary (cycle_clk) it is
//   compared with the one-hot prediction actL_alln. The first `warmup`
//   comparisons after reset are discarded while the pipeline fills. Results
//   are counted per window of `win` samples and handed out on a valid/ready
//   port.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   cycle_clk           block-boundary strobe (cycle_index == 0)
//   cycle_index         clock position within the block cycle
//   ansL                ideal-output bits for the current zo neurons
//   actL_alln           one-hot prediction for the block just ended
//   correct             1-clk pulse: counted sample was correct
//   sample_done         1-clk pulse: a counted comparison occurred
//   res_valid/ready     window result handshake
//   res_correct/total   correct / total samples of the delivered window
//   overrun             sticky: window completed while a result was pending
//   ans_err             sticky: collected ideal vector was not one-hot
module accuracy_monitor #(
    parameter int n_out  = 4,
    parameter int zo     = 1,
    parameter int cpc    = 6,
    parameter int warmup = 3,
    parameter int win    = 4,
    parameter int cw     = $clog2(win + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cycle_clk,
    input  logic [$clog2(cpc)-1:0]  cycle_index,
    input  logic [zo-1:0]           ansL,
    input  logic [n_out-1:0]        actL_alln,
    output logic                    correct,
    output logic                    sample_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [cw-1:0]           res_correct,
    output logic [cw-1:0]           res_total,
    output logic                    overrun,
    output logic                    ans_err
);

    localparam int IW    = $clog2(cpc);
    localparam int NSLOT = n_out / zo;
    localparam int WW    = (warmup > 0) ? $clog2(warmup + 1) : 1;

    typedef enum logic {WARMUP, RUN} state_t;

    // With no warmup the monitor counts from the very first compare edge.
    localparam state_t RST_STATE = (warmup == 0) ? RUN : WARMUP;
    localparam logic [WW-1:0] WARM_LAST = WW'((warmup > 0) ? warmup - 1 : 0);
    localparam logic [cw-1:0] WIN_LAST  = cw'(win - 1);
    localparam logic [cw-1:0] WIN_VAL   = cw'(win);

    state_t             state_q, state_d;
    logic [WW-1:0]      warm_cnt_q, warm_cnt_d;
    logic [n_out-1:0]   ans_vec_q, ans_vec_d;
    logic [cw-1:0]      win_cnt_q, win_cnt_d;
    logic [cw-1:0]      corr_cnt_q, corr_cnt_d;
    logic               correct_q, correct_d;
    logic               sample_done_q, sample_done_d;
    logic               res_valid_q, res_valid_d;
    logic [cw-1:0]      res_correct_q, res_correct_d;
    logic [cw-1:0]      res_total_q, res_total_d;
    logic               overrun_q, overrun_d;
    logic               ans_err_q, ans_err_d;

    logic               accept;
    logic               ans_onehot;
    logic               match;
    logic [cw-1:0]      corr_next;
    logic [IW-1:0]      slot;

    always_comb begin
        state_d       = state_q;
        warm_cnt_d    = warm_cnt_q;
        ans_vec_d     = ans_vec_q;
        win_cnt_d     = win_cnt_q;
        corr_cnt_d    = corr_cnt_q;
        correct_d     = 1'b0;
        sample_done_d = 1'b0;
        res_valid_d   = res_valid_q;
        res_correct_d = res_correct_q;
        res_total_d   = res_total_q;
        overrun_d     = overrun_q;
        ans_err_d     = ans_err_q;

        accept     = res_valid_q && res_ready;
        ans_onehot = (ans_vec_q != '0) && ((ans_vec_q & (ans_vec_q - n_out'(1))) == '0);
        // An all-zero prediction can never equal a one-hot answer.
        match      = ans_onehot && (actL_alln == ans_vec_q);
        corr_next  = corr_cnt_q + cw'(match);
        slot       = cycle_index - IW'(2);

        if (accept)
            res_valid_d = 1'b0;

        if (cycle_clk) begin
            ans_vec_d = '0;
            if (state_q == WARMUP) begin
                warm_cnt_d = warm_cnt_q + WW'(1);
                if (warm_cnt_q == WARM_LAST)
                    state_d = RUN;
            end else begin
                sample_done_d = 1'b1;
                correct_d     = match;
                if (!ans_onehot)
                    ans_err_d = 1'b1;
                if (win_cnt_q == WIN_LAST) begin
                    win_cnt_d  = '0;
                    corr_cnt_d = '0;
                    // Acceptance on the same edge frees the slot for the new result.
                    if (!res_valid_q || accept) begin
                        res_valid_d   = 1'b1;
                        res_correct_d = corr_next;
                        res_total_d   = WIN_VAL;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    win_cnt_d  = win_cnt_q + cw'(1);
                    corr_cnt_d = corr_next;
                end
            end
        end else if (cycle_index >= IW'(2)) begin
            // Clocks 0 and 1 of the block carry no answer bits.
            for (int s = 0; s < NSLOT; s++)
                if (slot == IW'(s))
                    ans_vec_d[s*zo +: zo] = ansL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RST_STATE;
            warm_cnt_q    <= '0;
            ans_vec_q     <= '0;
            win_cnt_q     <= '0;
            corr_cnt_q    <= '0;
            correct_q     <= 1'b0;
            sample_done_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_correct_q <= '0;
            res_total_q   <= '0;
            overrun_q     <= 1'b0;
            ans_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            warm_cnt_q    <= warm_cnt_d;
            ans_vec_q     <= ans_vec_d;
            win_cnt_q     <= win_cnt_d;
            corr_cnt_q    <= corr_cnt_d;
            correct_q     <= correct_d;
            sample_done_q <= sample_done_d;
            res_valid_q   <= res_valid_d;
            res_correct_q <= res_correct_d;
            res_total_q   <= res_total_d;
            overrun_q     <= overrun_d;
            ans_err_q     <= ans_err_d;
        end
    end

    assign correct     = correct_q;
    assign sample_done = sample_done_q;
    assign res_valid   = res_valid_q;
    assign res_correct = res_correct_q;
    assign res_total   = res_total_q;
    assign overrun     = overrun_q;
    assign ans_err     = ans_err_q;

endmodule

// File: tb/tb_accuracy_monitor.sv
module tb_accuracy_monitor;

    localparam int N_OUT  = 4;
    localparam int CPC    = 6;
    localparam int WARMUP = 3;
    localparam int WIN    = 4;
    localparam int CW     = $clog2(WIN + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             cycle_clk;
    logic [2:0]       cycle_index;
    logic [0:0]       ansL;
    logic [N_OUT-1:0] actL_alln;
    logic             correct, sample_done, res_valid, res_ready;
    logic [CW-1:0]    res_correct, res_total;
    logic             overrun, ans_err;

    accuracy_monitor #(.n_out(N_OUT), .zo(1), .cpc(CPC), .warmup(WARMUP), .win(WIN)) dut (
        .clk(clk), .reset(reset), .cycle_clk(cycle_clk), .cycle_index(cycle_index),
        .ansL(ansL), .actL_alln(actL_alln), .correct(correct), .sample_done(sample_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_correct(res_correct),
        .res_total(res_total), .overrun(overrun), .ans_err(ans_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int         m_warm, m_win, m_corr, m_rc, m_rt;
    bit         m_rv, m_ov, m_err;
    logic [3:0] m_ans;
    bit         m_cor, m_done;

    // scoreboard of expected {correct, sample_done} per compare edge
    logic [1:0] pq[$];

    // snapshot taken right after each compare edge
    logic       last_correct, last_done, last_rv;
    logic [CW-1:0] last_rc, last_rt;

    function automatic bit onehot(logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    task automatic model_reset();
        m_warm = 0; m_win = 0; m_corr = 0; m_rc = 0; m_rt = 0;
        m_rv = 0; m_ov = 0; m_err = 0; m_ans = 4'd0;
        pq.delete();
    endtask

    // Advance the model for the upcoming edge, clock it, then compare.
    task automatic tick();
        bit pushed, accept, match;
        logic [1:0] exp_p;
        pushed = 0;
        if (reset) begin
            model_reset();
        end else begin
            accept = m_rv && res_ready;
            m_cor = 0; m_done = 0;
            if (cycle_clk) begin
                match = onehot(m_ans) && (actL_alln == m_ans);
                if (m_warm < WARMUP) begin
                    m_warm++;
                end else begin
                    m_done = 1; m_cor = match;
                    if (!onehot(m_ans)) m_err = 1;
                    m_win++;
                    if (match) m_corr++;
                    if (m_win == WIN) begin
                        if (!m_rv || accept) begin
                            m_rv = 1; m_rc = m_corr; m_rt = WIN; accept = 0;
                        end else begin
                            m_ov = 1;
                        end
                        m_win = 0; m_corr = 0;
                    end
                end
                m_ans = 4'd0;
                pq.push_back({m_cor, m_done});
                pushed = 1;
            end else if (cycle_index >= 3'd2) begin
                m_ans[int'(cycle_index) - 2] = ansL[0];
            end
            if (accept) m_rv = 0;
        end
        @(posedge clk);
        #1;
        exp_p = pushed ? pq.pop_front() : 2'b00;
        n_checks++;
        if ({correct, sample_done} !== exp_p) begin
            n_err++;
            $display("FAIL pulses t=%0t got correct,done=%b%b want %b", $time, correct, sample_done, exp_p);
        end
        n_checks++;
        if (res_valid !== m_rv || res_correct !== CW'(m_rc) || res_total !== CW'(m_rt)) begin
            n_err++;
            $display("FAIL result t=%0t got v=%b c=%0d t=%0d want v=%b c=%0d t=%0d",
                     $time, res_valid, res_correct, res_total, m_rv, m_rc, m_rt);
        end
        n_checks++;
        if (overrun !== m_ov || ans_err !== m_err) begin
            n_err++;
            $display("FAIL sticky t=%0t got ovr=%b err=%b want ovr=%b err=%b",
                     $time, overrun, ans_err, m_ov, m_err);
        end
        if (pushed) begin
            last_correct = correct; last_done = sample_done; last_rv = res_valid;
            last_rc = res_correct; last_rt = res_total;
        end
    endtask

    // One block cycle: answer bits on cycle_index 2..5, then the compare
    // edge (cycle_index 0) presenting `act`, then cycle_index 1.
    task automatic do_sample(input logic [3:0] ans, input logic [3:0] act);
        for (int i = 2; i < CPC; i++) begin
            cycle_clk = 1'b0; cycle_index = 3'(i); ansL = ans[i-2];
            actL_alln = 4'($urandom_range(0, 15));
            tick();
        end
        cycle_clk = 1'b1; cycle_index = 3'd0; ansL = 1'($urandom_range(0, 1)); actL_alln = act;
        tick();
        cycle_clk = 1'b0; cycle_index = 3'd1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; cycle_clk = 1'b0; cycle_index = 3'd1; ansL = 1'b0;
        actL_alln = 4'd0; res_ready = 1'b0;
        model_reset();
        tick(); tick();
        n_checks++;
        if ({correct, sample_done, res_valid, overrun, ans_err} !== 5'b0 ||
            res_correct !== '0 || res_total !== '0) begin
            n_err++;
            $display("FAIL reset_state got %b %0d %0d want all zero",
                     {correct, sample_done, res_valid, overrun, ans_err}, res_correct, res_total);
        end
        reset = 1'b0;
    endtask

    task automatic test_warmup();
        logic [3:0] a;
        for (int k = 0; k < WARMUP; k++) begin
            a = 4'(1 << (k % 4));
            do_sample(a, a);
            n_checks++;
            if (last_done !== 1'b0 || last_correct !== 1'b0) begin
                n_err++;
                $display("FAIL warmup_pulse k=%0d got done=%b correct=%b want 0 0", k, last_done, last_correct);
            end
        end
    endtask

    task automatic test_correct();
        do_sample(4'b0100, 4'b0100);
        n_checks++;
        if (last_correct !== 1'b1 || last_done !== 1'b1) begin
            n_err++;
            $display("FAIL first_match got correct=%b done=%b want 1 1", last_correct, last_done);
        end
    endtask

    task automatic test_window();
        res_ready = 1'b1;
        do_sample(4'b0001, 4'b0010);
        do_sample(4'b1000, 4'b1000);
        do_sample(4'b0010, 4'b0010);
        n_checks++;
        if (last_rv !== 1'b1 || last_rc !== CW'(3) || last_rt !== CW'(4)) begin
            n_err++;
            $display("FAIL window_3of4 got v=%b c=%0d t=%0d want 1 3 4", last_rv, last_rc, last_rt);
        end
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL window_accept got res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_overrun();
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) do_sample(4'b0001, 4'b0001);
        n_checks++;
        if (last_rv !== 1'b1 || last_rc !== CW'(4)) begin
            n_err++;
            $display("FAIL win_4of4 got v=%b c=%0d want 1 4", last_rv, last_rc);
        end
        do_sample(4'b0100, 4'b0100);
        do_sample(4'b0100, 4'b0000);
        do_sample(4'b0010, 4'b1000);
        do_sample(4'b1000, 4'b0001);
        n_checks++;
        if (res_correct !== CW'(4) || overrun !== 1'b1 || res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun got c=%0d ovr=%b v=%b want 4 1 1", res_correct, overrun, res_valid);
        end
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_drain got res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_ans_err();
        do_sample(4'b0011, 4'b0011);
        n_checks++;
        if (ans_err !== 1'b1 || last_correct !== 1'b0 || last_done !== 1'b1) begin
            n_err++;
            $display("FAIL ans_err got err=%b correct=%b done=%b want 1 0 1", ans_err, last_correct, last_done);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) do_sample(4'b1000, 4'b1000);
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset got res_valid=%b want 1", res_valid);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({correct, sample_done, res_valid, overrun, ans_err} !== 5'b0 ||
            res_correct !== '0 || res_total !== '0) begin
            n_err++;
            $display("FAIL async_reset got %b %0d %0d want all zero",
                     {correct, sample_done, res_valid, overrun, ans_err}, res_correct, res_total);
        end
        model_reset();
        tick();
        reset = 1'b0;
        for (int k = 0; k < WARMUP; k++) begin
            do_sample(4'b0010, 4'b0010);
            n_checks++;
            if (last_done !== 1'b0) begin
                n_err++;
                $display("FAIL rewarm k=%0d got done=%b want 0", k, last_done);
            end
        end
        do_sample(4'b0010, 4'b0010);
        n_checks++;
        if (last_correct !== 1'b1 || last_done !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_match got correct=%b done=%b want 1 1", last_correct, last_done);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_correct();
        test_window();
        test_overrun();
        test_ans_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
